// File: rtl/fifo_wr_framer_if.sv
// Source stream and FIFO write-port bundle for fifo_wr_framer.
// slave is the framer's view; master is the environment driving the source and full flag.
interface fifo_wr_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  full;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (
        output full, s_valid, s_data, s_last,
        input  s_ready, winc, wdata
    );

    modport slave (
        input  full, s_valid, s_data, s_last,
        output s_ready, winc, wdata
    );
endinterface

// File: rtl/fifo_wr_framer.sv
// Write-side framer in front of an async FIFO: passes payload through, appends a {trunc,len} trailer.
// Optional FRAMER_STATS_EN adds trunc_cnt, counting trailers written with the truncation flag set.
module fifo_wr_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 wclk,
    input  logic                 rst_n,
    fifo_wr_framer_if.slave      wr_if,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_cnt
`ifdef FRAMER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] trunc_cnt
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIL = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 trunc_q, trunc_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    logic                  s_ready_c;
    logic                  winc_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic                  trailer_wr;

    // Truncation flag lives in the MSB, payload length zero-padded into the LSBs.
    function automatic logic [DATA_WIDTH-1:0] trailer_word(input logic trunc,
                                                           input logic [LEN_W-1:0] len);
        logic [DATA_WIDTH-1:0] w;
        w                 = '0;
        w[LEN_W-1:0]      = len;
        w[DATA_WIDTH-1]   = trunc;
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        frame_cnt_d = frame_cnt_q;
        s_ready_c   = 1'b0;
        winc_c      = 1'b0;
        wdata_c     = wr_if.s_data;
        trailer_wr  = 1'b0;

        unique case (state_q)
            IDLE, DATA: begin
                if (len_q < LEN_MAX) begin
                    s_ready_c = !wr_if.full;
                    winc_c    = wr_if.s_valid && !wr_if.full;
                    if (winc_c) begin
                        len_d = len_q + LEN_W'(1);
                    end
                end else begin
                    // Frame already holds MAX_LEN words: drain the excess without writing.
                    s_ready_c = 1'b1;
                    if (wr_if.s_valid) begin
                        trunc_d = 1'b1;
                    end
                end
                if (wr_if.s_valid && s_ready_c) begin
                    state_d = wr_if.s_last ? TRAIL : DATA;
                end
            end
            TRAIL: begin
                winc_c     = !wr_if.full;
                wdata_c    = trailer_word(trunc_q, len_q);
                trailer_wr = !wr_if.full;
                if (trailer_wr) begin
                    state_d     = IDLE;
                    len_d       = '0;
                    trunc_d     = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef FRAMER_STATS_EN
    logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    always_comb begin
        trunc_cnt_d = trunc_cnt_q;
        if (trailer_wr && trunc_q) begin
            trunc_cnt_d = trunc_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            trunc_cnt_q <= '0;
        end else begin
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign trunc_cnt = trunc_cnt_q;
`endif

    assign wr_if.s_ready = s_ready_c;
    assign wr_if.winc    = winc_c;
    assign wr_if.wdata   = wdata_c;
    assign busy          = (state_q != IDLE);
    assign frame_cnt     = frame_cnt_q;

endmodule
